multi_div: RTL and testbench
============================

MULTI_DIV -- requirements
Module: multi_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin a division, sampled only while busy=0.
REQ-005 The block SHALL have port dividend, input, WIDTH, the unsigned dividend, captured when start is accepted.
REQ-006 The block SHALL have port divisor, input, WIDTH, the unsigned divisor, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1, high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking quotient and remainder as valid.
REQ-009 The block SHALL have port quotient, output, WIDTH, the unsigned quotient.
REQ-010 The block SHALL have port remainder, output, WIDTH, the unsigned remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1, a flag set when the last accepted divisor was 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL be accepted, SHALL capture both operands, and SHALL clear div_by_zero.
- Divisor non-zero: next state is CALC.
- Divisor zero: next state is DONE.
REQ-014 busy SHALL be 1 exactly while in CALC; start SHALL be ignored while busy=1.
REQ-015 CALC SHALL run exactly WIDTH iterations, using an internal iteration counter from WIDTH-1 down to 0; after the iteration at count 0 the next state is DONE.
REQ-016 Each iteration SHALL be restoring shift-subtract on a (WIDTH+1)-bit partial remainder R and a quotient shift register Q, initialised to R=0 and Q=dividend.
- trial = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, divisor}.
- trial non-negative: R = trial; Q = {Q[WIDTH-2:0], 1}.
- Otherwise: R = {R[WIDTH-1:0], Q[WIDTH-1]}; Q = {Q[WIDTH-2:0], 0}.
REQ-017 Latency SHALL be fixed: start accepted at edge k gives busy=1 for cycles k+1..k+WIDTH and done=1 in cycle k+WIDTH+1 only.
REQ-018 quotient and remainder SHALL update only on entry to DONE, and SHALL hold their values until the next DONE entry or reset.
REQ-019 Divisor zero SHALL set done=1 in cycle k+1 with quotient = all ones, remainder = dividend and div_by_zero=1.
REQ-020 div_by_zero SHALL hold its value until the next accepted start.
REQ-021 DONE SHALL last one cycle.
- start=0 in DONE: next state is IDLE.
- start=1 in DONE: accepted per REQ-013 (back-to-back operation).
REQ-022 Operands changing after acceptance SHALL NOT affect the division in progress.
REQ-023 Results SHALL equal floor(dividend/divisor) and dividend mod divisor for all non-zero divisors, including dividend=0, dividend<divisor and divisor=1.

Reset
REQ-024 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and SHALL clear all internal registers.
REQ-025 rst SHALL take priority over start in the same cycle.
REQ-026 rst during CALC SHALL abort the division with no done pulse.

Verification (WIDTH=4)
REQ-027 start, 13/3 -> busy cycles 1-4, done in cycle 5, quotient=4, remainder=1, div_by_zero=0.
REQ-028 start, 7/0 -> done in cycle 1, quotient=15, remainder=7, div_by_zero=1, busy never 1.
REQ-029 Sweep 15/1, 2/9 and 0/5 -> 15r0, 0r2 and 0r0, each at 5-cycle latency.
REQ-030 start, 9/2; re-assert start with 1/1 during busy -> second request ignored; result 4r1; outputs held after done.
REQ-031 start asserted during the DONE cycle of 13/3, with 14/4 -> second result 3r2 exactly 5 cycles later.
REQ-032 rst asserted in cycle 2 of 13/3 -> no done pulse; all outputs 0; a subsequent 6/2 gives 3r0.

Source files
------------

// File: rtl/multi_div.sv
// Sequential restoring divider: one quotient bit per cycle, fixed WIDTH-cycle latency.
// A zero divisor skips the iterations and reports all-ones quotient, dividend remainder.
module multi_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;

  // Partial remainder stays below the divisor, so r needs only WIDTH bits and the
  // subtraction result fits in WIDTH bits whenever the trial is non-negative.
  always_comb begin
    shifted = {r, q[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvsr});
    diff    = shifted[WIDTH-1:0] - dvsr;
    r_nxt   = ge ? diff : shifted[WIDTH-1:0];
    q_nxt   = q << 1;
    q_nxt[0] = ge;
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dvsr        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            r           <= '0;
            q           <= dividend;
            dvsr        <= divisor;
            cnt         <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          r <= r_nxt;
          q <= q_nxt;
          if (cnt == '0) begin
            state     <= DONE;
            quotient  <= q_nxt;
            remainder <= r_nxt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_div.sv
// Directed bench for multi_div (WIDTH=4): latency, results, zero divisor,
// ignored starts, back-to-back operation and mid-calculation reset.
module tb_multi_div;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_div #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Called at a negedge; returns at the negedge of cycle 1 after acceptance,
  // with operands scrambled so later changes must not matter.
  task automatic kick(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = ~a;
    divisor  = a ^ b ^ 4'd5;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    kick(4'd13, 4'd3);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      checks++;
      if (busy !== (c <= 4) || done !== (c == 5)) begin
        failures++;
        $display("FAIL basic_timing c=%0d: got busy=%b done=%b, want %b %b",
                 c, busy, done, c <= 4, c == 5);
      end
    end
    checks++;
    if (quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL basic_13_3: got q=%0d r=%0d dbz=%b, want 4 1 0",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    kick(4'd7, 4'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || quotient !== 4'd15 || remainder !== 4'd7 ||
        div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL div_zero: got done=%b busy=%b q=%0d r=%0d dbz=%b, want 1 0 15 7 1",
               done, busy, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 4'd15) begin
      failures++;
      $display("FAIL div_zero_hold: got done=%b busy=%b dbz=%b q=%0d, want 0 0 1 15",
               done, busy, div_by_zero, quotient);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] va [3] = '{4'd15, 4'd2, 4'd0};
    logic [W-1:0] vb [3] = '{4'd1,  4'd9, 4'd5};
    logic [W-1:0] vq [3] = '{4'd15, 4'd0, 4'd0};
    logic [W-1:0] vr [3] = '{4'd0,  4'd2, 4'd0};
    for (int i = 0; i < 3; i++) begin
      kick(va[i], vb[i]);
      repeat (4) @(negedge clk);
      checks++;
      if (done !== 1'b1 || quotient !== vq[i] || remainder !== vr[i] || div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL sweep_%0d_%0d: got done=%b q=%0d r=%0d dbz=%b, want 1 %0d %0d 0",
                 va[i], vb[i], done, quotient, remainder, div_by_zero, vq[i], vr[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_busy();
    kick(4'd9, 4'd2);
    start = 1'b1; dividend = 4'd1; divisor = 4'd1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_busy: got busy=%b done=%b in cycle 3, want 1 0", busy, done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd1) begin
      failures++;
      $display("FAIL ignore_9_2: got done=%b q=%0d r=%0d, want 1 4 1", done, quotient, remainder);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 4'd4 || remainder !== 4'd1) begin
      failures++;
      $display("FAIL hold_after_done: got done=%b busy=%b q=%0d r=%0d, want 0 0 4 1",
               done, busy, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    kick(4'd13, 4'd3);
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd1) begin
      failures++;
      $display("FAIL b2b_first: got done=%b q=%0d r=%0d, want 1 4 1", done, quotient, remainder);
    end
    kick(4'd14, 4'd4);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      checks++;
      if (busy !== (c <= 4) || done !== (c == 5)) begin
        failures++;
        $display("FAIL b2b_timing c=%0d: got busy=%b done=%b, want %b %b",
                 c, busy, done, c <= 4, c == 5);
      end
    end
    checks++;
    if (quotient !== 4'd3 || remainder !== 4'd2) begin
      failures++;
      $display("FAIL b2b_14_4: got q=%0d r=%0d, want 3 2", quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    kick(4'd13, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
        failures++;
        $display("FAIL reset_mid c=%0d: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                 c, busy, done, quotient, remainder, div_by_zero);
      end
      @(negedge clk);
    end
    kick(4'd6, 4'd2);
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1 || quotient !== 4'd3 || remainder !== 4'd0) begin
      failures++;
      $display("FAIL after_reset_6_2: got done=%b q=%0d r=%0d, want 1 3 0",
               done, quotient, remainder);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_div_zero();
    test_sweep();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
